// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline stage.
//   ctrl_t        - packed control bundle, same bit order as in_ctrl
//   CTRL_*        - bit positions of each control bit inside in_ctrl/out_ctrl
//   *_DEF         - default parameter values for ex_mem_stage
package ex_mem_pkg;

  localparam int PC_W_DEF   = 64;
  localparam int DATA_W_DEF = 64;
  localparam int RD_W_DEF   = 5;
  localparam int F3_W_DEF   = 3;
  localparam int CNT_W_DEF  = 16;
  localparam int CTRL_W     = 5;

  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 0;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic branch;
    logic mem_write;
    logic mem_read;
  } ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry (head + skid) valid/ready buffer.
//   CLK, RST (async, active low), flush
//   in_valid/in_ready/in_data   - upstream side; in_ready is a flop output
//   out_valid/out_ready/out_data - downstream side, straight from head regs
//   occupancy                    - held entries, 0..2
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic         head_vld, skid_vld, rdy_q;
  logic         head_vld_nx, skid_vld_nx;
  logic [W-1:0] head_q, skid_q, head_nx, skid_nx;
  logic         acc, cons;

  assign acc  = in_valid & rdy_q;
  assign cons = head_vld & out_ready;

  always_comb begin
    head_vld_nx = head_vld;
    skid_vld_nx = skid_vld;
    head_nx     = head_q;
    skid_nx     = skid_q;
    if (flush) begin
      head_vld_nx = 1'b0;
      skid_vld_nx = 1'b0;
    end else if (!head_vld) begin
      if (acc) begin
        head_nx     = in_data;
        head_vld_nx = 1'b1;
      end
    end else if (!skid_vld) begin
      if (acc && cons) begin
        head_nx = in_data;
      end else if (acc) begin
        skid_nx     = in_data;
        skid_vld_nx = 1'b1;
      end else if (cons) begin
        head_vld_nx = 1'b0;
      end
    end else if (cons) begin
      // rdy_q is low here, so no new entry can arrive in the same cycle
      head_nx     = skid_q;
      skid_vld_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      head_vld <= head_vld_nx;
      skid_vld <= skid_vld_nx;
      // registered ready: next-state skid empty, no path from out_ready/flush
      rdy_q    <= ~skid_vld_nx;
      head_q   <= head_nx;
      skid_q   <= skid_nx;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = head_vld;
  assign out_data  = head_q;
  assign occupancy = {head_vld & skid_vld, head_vld ^ skid_vld};

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready on both sides.
//   CLK, RST (async, active low), flush, clr_cnt
//   in_*  - EX-side entry (pc, alu_result, rd, ctrl, funct3, zero, less)
//   out_* - MEM-side head entry; out_ctrl forced to 0 while out_valid=0
//   occupancy - held entries; stall_cnt - saturating out_valid&!out_ready cycles
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int F3_W   = F3_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [4:0]        in_ctrl,
  input  logic [F3_W-1:0]   in_funct3,
  input  logic              in_zero,
  input  logic              in_less,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [4:0]        out_ctrl,
  output logic [F3_W-1:0]   out_funct3,
  output logic              out_zero,
  output logic              out_less,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int W = PC_W + DATA_W + RD_W + CTRL_W + F3_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] in_pl, out_pl;
  ctrl_t        in_c, head_c;

  assign in_c  = ctrl_t'(in_ctrl);
  assign in_pl = {in_pc, in_alu_result, in_rd, in_c, in_funct3, in_zero, in_less};

  pipe_skid_buf #(.W(W)) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl),
    .occupancy (occupancy)
  );

  assign {out_pc, out_alu_result, out_rd, head_c, out_funct3, out_zero, out_less} = out_pl;
  assign out_ctrl = out_valid ? head_c : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                          stall_cnt <= '0;
    else if (clr_cnt)                                  stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage for the pipelined core, with a valid/ready handshake on both sides. A 2-entry skid buffer lets the memory stage stall without a combinational ready path back into EX. A flush turns the stage into bubbles, and a saturating stall counter supports performance analysis. It sits between the ALU/branch-compare logic and data memory and replaces the fixed-width, always-advancing EX/MEM register.

## Interface
- PC_W, 64, program-counter / branch-target width
- DATA_W, 64, ALU result width
- RD_W, 5, destination register index width
- F3_W, 3, funct3 width
- CNT_W, 16, stall counter width
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  kill all held entries and any entry offered this cycle
- clr_cnt  in  1  synchronous clear of stall_cnt
- in_valid  in  1  EX offers an entry
- in_ready  out  1  stage can accept; registered, equals "skid entry empty"
- in_pc  in  PC_W  next PC / branch target
- in_alu_result  in  DATA_W  ALU result / memory address
- in_rd  in  RD_W  destination register
- in_ctrl  in  5  {mem_to_reg, reg_write, branch, mem_write, mem_read}
- in_funct3  in  F3_W  load/store/branch subtype
- in_zero, in_less  in  1 each  ALU flags
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes the head entry
- out_pc, out_alu_result, out_rd, out_ctrl, out_funct3, out_zero, out_less  out  as inputs  head entry payload
- occupancy  out  2  number of held entries, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- The stage holds two entries: head (main) and skid. Occupancy states are EMPTY (0), ONE (head only) and TWO (head + skid).
- An input is accepted when in_valid && in_ready. The head is consumed when out_valid && out_ready.
- EMPTY: on accept, the input goes to the head → ONE.
- ONE:
  - accept and consume: the input replaces the head → ONE.
  - accept only: the input goes to skid → TWO.
  - consume only: → EMPTY.
- TWO (in_ready=0): on consume, skid moves to head and skid clears → ONE. Otherwise hold.
- Order is strictly preserved. No entry is duplicated or dropped except by flush.
- flush=1 forces state EMPTY next cycle and discards any input offered that cycle. Flush has priority over accept and consume.
- While out_valid=0, out_ctrl is forced to 0, so no spurious reg_write or mem_write reaches MEM. The other out_* payload fields hold their last value and are don't-care.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready and saturates at 2^CNT_W−1.
  - clr_cnt zeroes it and takes priority over an increment in the same cycle.
  - flush does not clear it.
- Reset: state EMPTY; all payload registers, out_ctrl, out_valid, occupancy and stall_cnt are 0; in_ready=1 while RST=0 and from the first cycle after release. Reset asserted mid-operation discards both entries immediately (asynchronously).

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, so it is consumable in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready is a pure register output, with no combinational path from out_ready or flush.
- out_valid and out_* come directly from the head register. out_ctrl is gated only by out_valid.
- After a stall releases, in_ready returns to 1 one cycle after the consume that empties skid.
- After flush at edge N: out_valid=0, occupancy=0 and in_ready=1 after edge N.

## Structure
- Package ex_mem_pkg holds:
  - ctrl_t, a packed struct of the five control bits in the in_ctrl order;
  - bit-index constants CTRL_MEM_TO_REG … CTRL_MEM_READ;
  - default parameter constants.
- Sub-module pipe_skid_buf #(W) is generic: a 2-entry buffer with valid/ready, flush and occupancy, carrying one packed payload. ex_mem_stage concatenates the fields into that payload, adds the out_ctrl gating and the stall counter.

## Test plan
- Reset then stream: in_valid=1, out_ready=1 for 4 cycles with alu_result 0x10,0x20,0x30,0x40 → out_valid rises 1 cycle later, values appear in order one per cycle, in_ready stays 1, stall_cnt=0.
- Back-pressure: hold out_ready=0 while offering 0xA,0xB,0xC:
  - 0xA goes to head, 0xB to skid, then in_ready=0 and 0xC is held upstream; occupancy=2.
  - On release, out_* shows 0xA, 0xB, 0xC and stall_cnt equals the stalled cycle count.
- Flush with occupancy=2 and in_valid=1 (ctrl=5'b01000) → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and the offered entry never appears.
- Saturation: CNT_W=3, stall 10 cycles → stall_cnt stops at 7. Assert clr_cnt during a stall cycle → stall_cnt=0 next cycle.
- Async reset mid-stall with occupancy=2: drop RST between edges → out_valid, occupancy and stall_cnt read 0 before the next edge. After release, a new entry 0x55 passes with 1-cycle latency.
- Simultaneous accept and consume in ONE with out_ready=1: the head is replaced each cycle, occupancy stays 1 and no skid use occurs.
